// File: rtl/sram_bridge.sv
// Byte-wide core bus to 16-bit asynchronous SRAM bridge with a one-word read buffer.
// Read hits complete with zero wait states; misses and writes hold the core with core_ready.
module sram_bridge #(
  parameter int WAIT = 2  // SRAM strobe cycles per access, minimum 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] core_address,
  input  logic [7:0]  core_out,
  input  logic        core_we,
  output logic [7:0]  core_in,
  output logic        core_ready,
  output logic [18:0] sram_a,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_WDONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [15:0]     rbuf;
  logic [18:0]     tag;
  logic            valid;
  logic            a0;
  logic            hit;
  logic            cnt_zero;

  // Tag compare feeds core_ready and core_in directly; keep it unregistered.
  assign hit      = valid && (tag == core_address[19:1]);
  assign cnt_zero = (cnt == '0);
  assign core_in  = core_address[0] ? rbuf[15:8] : rbuf[7:0];

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_nx   = state;
    core_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (core_we) begin
          state_nx = S_WRITE;
        end else if (hit) begin
          core_ready = 1'b1;
        end else begin
          state_nx = S_READ;
        end
      end
      S_READ: begin
        if (cnt_zero) state_nx = S_IDLE;
      end
      S_WRITE: begin
        if (cnt_zero) state_nx = S_WDONE;
      end
      S_WDONE: begin
        core_ready = 1'b1;
        state_nx   = S_IDLE;
      end
    endcase
    if (!reset_n) core_ready = 1'b0;
  end

  // Strobes, address and counter: all registered and changed only on state entry.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      sram_a     <= '0;
      cnt        <= '0;
      tag        <= '0;
      valid      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (state_nx == S_READ) begin
            sram_a     <= core_address[19:1];
            cnt        <= CNT_LOAD;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b0;
            sram_lb_n  <= 1'b0;
            sram_dq_oe <= 1'b0;
          end else if (state_nx == S_WRITE) begin
            sram_a     <= core_address[19:1];
            cnt        <= CNT_LOAD;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b0;
            sram_ub_n  <= ~core_address[0];
            sram_lb_n  <= core_address[0];
            sram_dq_oe <= 1'b1;
          end
        end
        S_READ: begin
          if (cnt_zero) begin
            tag       <= sram_a;
            valid     <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WRITE: begin
          // Only the write strobe rises into WDONE; chip enable, lanes,
          // address and data stay put to give the SRAM its hold time.
          if (cnt_zero) begin
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WDONE: begin
          sram_ce_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

  // Data-only registers: contents are meaningless until valid is set, so
  // NOTE: they carry no reset; only the qualifying flag (valid) is reset.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && state_nx == S_WRITE) begin
      sram_dq_o <= {core_out, core_out};
      a0        <= core_address[0];
    end
    if (reset_n && state == S_READ && cnt_zero) begin
      rbuf <= sram_dq_i;
    end
    // Write-through: keep the buffered word coherent with the SRAM.
    if (reset_n && state == S_WDONE && valid && tag == sram_a) begin
      if (a0) rbuf[15:8] <= sram_dq_o[15:8];
      else    rbuf[7:0]  <= sram_dq_o[7:0];
    end
  end

endmodule

// File: doc/sram_bridge.md
# sram_bridge

Byte-bus to 16-bit asynchronous SRAM bridge placed directly downstream of the 8088 core. It takes the core's 20-bit byte address, write strobe and write byte, and returns the read byte through a one-word read buffer. It runs multi-cycle SRAM read and write cycles and holds the core with `core_ready` while a cycle is in flight. At top level, `core_ready` is ANDed with PLL lock to form the core's `locked` enable.

## Interface
- `WAIT`, 2, number of SRAM strobe cycles per access; minimum 1.
- `clock`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `core_address`  in  20  byte address from core.
- `core_out`  in  8  write byte from core.
- `core_we`  in  1  write request; every cycle with `core_we=1` is one byte write.
- `core_in`  out  8  read byte to core; combinational.
- `core_ready`  out  1  core may advance this cycle; combinational.
- `sram_a`  out  19  SRAM word address (`core_address[19:1]`).
- `sram_dq_i`  in  16  SRAM data in.
- `sram_dq_o`  out  16  SRAM data out (`{core_out, core_out}`).
- `sram_dq_oe`  out  1  data bus drive enable.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  chip enable, output enable and write strobe; all active-low.
- `sram_ub_n`, `sram_lb_n`  out  1 each  upper and lower byte lane enables; active-low.

## Operation
- Read buffer: `buf[15:0]`, `tag[18:0]`, `valid`.
  - `core_in = core_address[0] ? buf[15:8] : buf[7:0]` (little-endian).
- Hit: `valid && tag == core_address[19:1]`.
- States are IDLE, READ, WRITE and WDONE. A down-counter `cnt` times the READ and WRITE states.
- IDLE:
  - `core_we=0` and hit: `core_ready=1`; stay in IDLE.
  - `core_we=0` and miss: `core_ready=0`; latch the word address; go to READ with `cnt=WAIT-1`.
  - `core_we=1`: `core_ready=0`; latch the address, data and byte lane; go to WRITE with `cnt=WAIT-1`.
  - A write never completes from IDLE, even when the address hits.
- READ:
  - Outputs: `ce_n=0`, `oe_n=0`, `ub_n=lb_n=0`, `dq_oe=0`.
  - On the edge where `cnt==0`: `buf<=sram_dq_i`, `tag<=` latched address, `valid<=1`; go to IDLE.
- WRITE:
  - Outputs: `ce_n=0`, `we_n=0`, `dq_oe=1`.
  - Byte lanes: `ub_n=~a0`, `lb_n=a0`, where `a0` is the latched `core_address[0]`.
  - On `cnt==0`, go to WDONE.
- WDONE:
  - Outputs: `we_n=1`; `ce_n`, `dq_oe`, address and data held for hold time.
  - `core_ready=1` for exactly this cycle.
  - If the latched word equals `tag` and `valid`, the addressed byte of `buf` is updated with the written byte (write-through coherence).
  - Writes to other words leave the buffer untouched.
  - Go to IDLE.
- `core_ready=0` in READ and WRITE.
- SRAM strobes, `sram_a` and `sram_dq_o` are registered and change only on state entry. Address and data are stable across the whole access.
- Master rule: the core holds address, `we` and data while `core_ready=0`.
  - The bridge uses the latched values during an access.
  - After READ it re-evaluates the hit in IDLE, so a changed address simply misses again.
- Repeated writes of the same byte to the same address each cost a full write cycle. No write merging.

## Timing
- Reset (`reset_n=0` at an edge):
  - `state=IDLE`, `valid=0`.
  - `ce_n=oe_n=we_n=ub_n=lb_n=1`, `dq_oe=0`, `sram_a=0`.
  - `core_ready` forced to 0 while `reset_n=0`.
- Reset mid-access aborts at that edge. Strobes are deasserted and a partial read does not fill the buffer.
- Read hit: 0 wait states; data valid in the same cycle.
- Read miss: `core_ready` low for `1+WAIT` cycles; data accepted in cycle `WAIT+2` (4 with `WAIT=2`).
- Write: `core_ready` low for `1+WAIT` cycles; completes in cycle `WAIT+2` (WDONE).
- Back-to-back: WDONE is followed by IDLE; the next access starts decode in that IDLE cycle.
- Critical path: `core_address` → tag compare → `core_ready` / `core_in` → core enable. No registers on this path.
- `tag` is 19 bits and the compare ignores bit 0. Address `FFFFF` maps to word `7FFFF`, upper lane. No wrap logic is needed.

## Test plan
- Reset, then hold `core_address=00000`, read, `WAIT=2`, SRAM word 0 = `0xBEEF`:
  - `core_ready` is 0 for 3 cycles.
  - `core_ready=1` in cycle 4 with `core_in=0xEF`.
- Continue from the previous scenario with a read at `00001`: `core_ready=1` in the same cycle with `core_in=0xBE`, no SRAM strobes.
- Write `0x55` to `00001`:
  - `we_n` low for 2 cycles, `ub_n=0`, `lb_n=1`, `sram_dq_o=0x5555`.
  - `core_ready` pulses only in WDONE.
  - A following read at `00001` hits and returns `0x55`.
- Write to `00400` while the buffer holds word 0: SRAM cycle runs, buffer still returns `0xEF` at `00000` with no stall.
- Reset mid-access: assert `reset_n=0` during the second READ cycle.
  - Next edge: all strobes are 1 and `valid=0`.
  - A read at `00000` after release misses again and stalls 3 cycles.
- Read `FFFFF`: `sram_a=7FFFF` and `core_in` equals the upper byte of the SRAM word.
